// File: rtl/sel_mux_pkg.sv
// Shared types and constants for the dwell-qualified channel selector.
//   state_t    : selector FSM state (LOCK = candidate matches committed channel,
//                QUAL = a different candidate is being qualified)
//   DEFAULT_CH : channel used when the request is disabled or out of range
//   CNT_W      : width of the qualification counter
package sel_mux_pkg;

    typedef enum logic {
        LOCK = 1'b0,
        QUAL = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_CH = 0;
    localparam int unsigned CNT_W      = 8;

endpackage

// File: rtl/dwell_counter.sv
// Qualification counter for the channel selector.
//   clk, aresetn : clock, asynchronous active-low reset
//   clear        : force count to 0 (highest priority)
//   load         : start a new qualification (count = 1)
//   inc          : another matching edge; saturates at DWELL
//   cnt          : current count
//   done         : the next inc reaches DWELL
module dwell_counter
    import sel_mux_pkg::*;
#(
    parameter int unsigned DWELL = 3
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             clear,
    input  logic             load,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    localparam logic [CNT_W-1:0] DWELL_V = CNT_W'(DWELL);
    localparam logic [CNT_W-1:0] DONE_AT = CNT_W'(DWELL - 1);

    // Count register: clear > load > saturating increment
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(1);
        end else if (inc && (cnt < DWELL_V)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign done = (cnt == DONE_AT);

endmodule

// File: rtl/sel_mux_dwell.sv
// Channel selector that only switches after a new request has been held for
// DWELL consecutive edges.
//   clk, aresetn  : clock, asynchronous active-low reset
//   in_data       : NCH packed channels, channel k at [k*WIDTH +: WIDTH]
//   sel           : requested channel, honoured only when sel_en1 & sel_en2
//   out_data      : registered data of the committed channel (1-cycle latency)
//   out_sel       : committed channel
//   pending       : a switch request is being qualified
//   switch_done   : one-cycle pulse after each commit
module sel_mux_dwell
    import sel_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4,
    parameter int unsigned DWELL = 3
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic [NCH*WIDTH-1:0]     in_data,
    input  logic [$clog2(NCH)-1:0]   sel,
    input  logic                     sel_en1,
    input  logic                     sel_en2,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(NCH)-1:0]   out_sel,
    output logic                     pending,
    output logic                     switch_done
);

    localparam int unsigned SEL_W = $clog2(NCH);

    state_t             state;
    state_t             state_nxt;
    logic [SEL_W-1:0]   cand_c;
    logic [SEL_W-1:0]   cand_r;
    logic [WIDTH-1:0]   data_mux_c;
    logic               ctr_clear;
    logic               ctr_load;
    logic               ctr_inc;
    logic               ctr_done;
    logic               commit_c;
    logic               capture_c;
    // count value is observed only through done here
    logic [CNT_W-1:0]   cnt_unused;

    // Candidate: qualified, in-range request, else the default channel
    always_comb begin
        cand_c = SEL_W'(DEFAULT_CH);
        if (sel_en1 && sel_en2 && (32'(sel) < NCH)) begin
            cand_c = sel;
        end
    end

    // State register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= LOCK;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a DWELL of 1 commits straight from LOCK
    always_comb begin
        state_nxt = state;
        case (state)
            LOCK: begin
                if ((cand_c != out_sel) && (DWELL > 1)) begin
                    state_nxt = QUAL;
                end
            end
            QUAL: begin
                if (cand_c == out_sel) begin
                    state_nxt = LOCK;
                end else if ((cand_c == cand_r) && ctr_done) begin
                    state_nxt = LOCK;
                end
            end
            default: state_nxt = LOCK;
        endcase
    end

    // Control strobes for the counter, candidate capture and commit
    always_comb begin
        ctr_clear = 1'b0;
        ctr_load  = 1'b0;
        ctr_inc   = 1'b0;
        commit_c  = 1'b0;
        capture_c = 1'b0;
        case (state)
            LOCK: begin
                if (cand_c != out_sel) begin
                    capture_c = 1'b1;
                    if (DWELL == 1) begin
                        commit_c  = 1'b1;
                        ctr_clear = 1'b1;
                    end else begin
                        ctr_load = 1'b1;
                    end
                end
            end
            QUAL: begin
                if (cand_c == out_sel) begin
                    ctr_clear = 1'b1;
                end else if (cand_c == cand_r) begin
                    if (ctr_done) begin
                        commit_c  = 1'b1;
                        ctr_clear = 1'b1;
                    end else begin
                        ctr_inc = 1'b1;
                    end
                end else begin
                    ctr_load  = 1'b1;
                    capture_c = 1'b1;
                end
            end
            default: ctr_clear = 1'b1;
        endcase
    end

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell_counter (
        .clk     (clk),
        .aresetn (aresetn),
        .clear   (ctr_clear),
        .load    (ctr_load),
        .inc     (ctr_inc),
        .cnt     (cnt_unused),
        .done    (ctr_done)
    );

    // Output data mux on the pre-edge committed channel
    always_comb begin
        data_mux_c = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (out_sel == SEL_W'(k)) begin
                data_mux_c = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Registered outputs and captured candidate
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cand_r      <= '0;
            out_sel     <= '0;
            out_data    <= '0;
            pending     <= 1'b0;
            switch_done <= 1'b0;
        end else begin
            if (capture_c) begin
                cand_r <= cand_c;
            end
            if (commit_c) begin
                out_sel <= cand_c;
            end
            out_data    <= data_mux_c;
            pending     <= (state_nxt == QUAL);
            switch_done <= commit_c;
        end
    end

endmodule

// File: tb/tb_sel_mux_dwell.sv
// Self-checking bench for sel_mux_dwell: instance A (NCH=4, DWELL=3) and
// instance B (NCH=3, DWELL=1), each compared every cycle against a run-length
// model of the dwell rule, plus literal expectations for the named scenarios.
module tb_sel_mux_dwell;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    // Instance A
    logic [31:0] in_a;
    logic [1:0]  sel_a;
    logic        e1a, e2a;
    logic [7:0]  od_a;
    logic [1:0]  os_a;
    logic        pend_a, sd_a;

    // Instance B
    logic [23:0] in_b;
    logic [1:0]  sel_b;
    logic        e1b, e2b;
    logic [7:0]  od_b;
    logic [1:0]  os_b;
    logic        pend_b, sd_b;

    sel_mux_dwell #(.WIDTH(8), .NCH(4), .DWELL(3)) dut_a (
        .clk(clk), .aresetn(aresetn), .in_data(in_a), .sel(sel_a),
        .sel_en1(e1a), .sel_en2(e2a), .out_data(od_a), .out_sel(os_a),
        .pending(pend_a), .switch_done(sd_a)
    );

    sel_mux_dwell #(.WIDTH(8), .NCH(3), .DWELL(1)) dut_b (
        .clk(clk), .aresetn(aresetn), .in_data(in_b), .sel(sel_b),
        .sel_en1(e1b), .sel_en2(e2b), .out_data(od_b), .out_sel(os_b),
        .pending(pend_b), .switch_done(sd_b)
    );

    int errors = 0;
    int checks = 0;
    bit run_cmp = 1'b1;
    bit b_done = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: committed channel plus the run length of the current differing candidate
    typedef struct {
        int committed;
        int last;
        int run;
        int pulse;
        int od;
    } mdl_t;

    function automatic mdl_t mstep(input mdl_t m, input int nch, input int dwell,
                                   input logic [31:0] din, input int sel, input bit en);
        mdl_t n;
        int cand;
        n = m;
        cand = (en && sel < nch) ? sel : 0;
        n.od = int'((din >> (8 * m.committed)) & 32'hFF);
        n.pulse = 0;
        if (cand == m.committed) begin
            n.run = 0;
        end else begin
            if (m.run > 0 && cand == m.last) begin
                n.run = m.run + 1;
            end else begin
                n.run = 1;
                n.last = cand;
            end
            if (n.run == dwell) begin
                n.committed = cand;
                n.run = 0;
                n.pulse = 1;
            end
        end
        return n;
    endfunction

    mdl_t ma, mb;

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            ma <= '{0, 0, 0, 0, 0};
            mb <= '{0, 0, 0, 0, 0};
        end else begin
            ma <= mstep(ma, 4, 3, in_a, int'(sel_a), e1a & e2a);
            mb <= mstep(mb, 3, 1, {8'h00, in_b}, int'(sel_b), e1b & e2b);
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (run_cmp) begin
            chk("a_out_data", int'(od_a), ma.od);
            chk("a_out_sel", int'(os_a), ma.committed);
            chk("a_pending", int'(pend_a), (ma.run > 0) ? 1 : 0);
            chk("a_switch_done", int'(sd_a), ma.pulse);
            chk("b_out_data", int'(od_b), mb.od);
            chk("b_out_sel", int'(os_b), mb.committed);
            chk("b_pending", int'(pend_b), (mb.run > 0) ? 1 : 0);
            chk("b_switch_done", int'(sd_b), mb.pulse);
        end
    end

    task automatic edge_a();
        @(negedge clk);
    endtask

    // Instance B directed sequence
    initial begin : stim_b
        logic [1:0] tsel [8];
        logic       ten  [8];
        in_b = 24'hCCBBAA; sel_b = 2'd0; e1b = 1'b1; e2b = 1'b1;
        tsel = '{2'd2, 2'd2, 2'd3, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};
        ten  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        @(posedge aresetn);
        // out-of-range request behaves as channel 0
        sel_b = 2'd3;
        edge_a();
        chk("b_oor_sel", int'(os_b), 0);
        chk("b_oor_pulse", int'(sd_b), 0);
        sel_b = 2'd1;
        edge_a();
        chk("b_dwell1_sel", int'(os_b), 1);
        chk("b_dwell1_pulse", int'(sd_b), 1);
        sel_b = 2'd2;
        edge_a();
        chk("b_data_ch1", int'(od_b), 8'hBB);
        chk("b_back2back_pulse", int'(sd_b), 1);
        chk("b_back2back_sel", int'(os_b), 2);
        for (int i = 0; i < 8; i++) begin
            sel_b = tsel[i];
            e2b = ten[i];
            edge_a();
        end
        b_done = 1'b1;
    end

    // Instance A directed sequence
    initial begin : stim_a
        int pulses;
        in_a = 32'h44332211; sel_a = 2'd0; e1a = 1'b1; e2a = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_sel", int'(os_a), 0);
        chk("rst_out_data", int'(od_a), 0);
        chk("rst_pending", int'(pend_a), 0);
        chk("rst_switch_done", int'(sd_a), 0);
        aresetn = 1'b1;

        // Hold sel=2: commit at edge 3, pulse seen at edge 4
        sel_a = 2'd2;
        edge_a();
        chk("hold_e1_pending", int'(pend_a), 1);
        chk("hold_e1_sel", int'(os_a), 0);
        edge_a();
        edge_a();
        chk("hold_e3_sel", int'(os_a), 2);
        chk("hold_e3_pulse", int'(sd_a), 1);
        chk("hold_e3_pending", int'(pend_a), 0);
        edge_a();
        chk("hold_e4_data", int'(od_a), 8'h33);
        chk("hold_e4_pulse", int'(sd_a), 0);

        // Drop sel_en1 while locked on 2: back to default after 3 edges
        e1a = 1'b0;
        edge_a();
        edge_a();
        chk("drop_e2_sel", int'(os_a), 2);
        edge_a();
        chk("drop_e3_sel", int'(os_a), 0);
        chk("drop_e3_pulse", int'(sd_a), 1);
        edge_a();
        chk("drop_e4_pulse", int'(sd_a), 0);
        e1a = 1'b1; sel_a = 2'd0;

        // sel=2 for 2 edges, then sel=3 for 3 edges: restart, commit on 3
        sel_a = 2'd2;
        edge_a();
        edge_a();
        sel_a = 2'd3;
        edge_a();
        chk("restart_pending", int'(pend_a), 1);
        chk("restart_pulse", int'(sd_a), 0);
        edge_a();
        chk("restart_e4_pending", int'(pend_a), 1);
        edge_a();
        chk("restart_e5_sel", int'(os_a), 3);
        chk("restart_e5_pulse", int'(sd_a), 1);
        sel_a = 2'd0;
        repeat (4) edge_a();
        chk("return0_sel", int'(os_a), 0);

        // Alternating sel_en2 never lets the candidate dwell
        sel_a = 2'd1;
        for (int i = 0; i < 8; i++) begin
            e2a = (i % 2 == 0);
            edge_a();
        end
        chk("toggle_sel", int'(os_a), 0);
        e2a = 1'b1; sel_a = 2'd0;
        edge_a();

        // Reset in the middle of qualification
        sel_a = 2'd2;
        edge_a();
        edge_a();
        chk("midq_pending", int'(pend_a), 1);
        #2 aresetn = 1'b0;
        #1;
        chk("async_out_data", int'(od_a), 0);
        chk("async_out_sel", int'(os_a), 0);
        chk("async_pending", int'(pend_a), 0);
        chk("async_switch_done", int'(sd_a), 0);
        sel_a = 2'd0;
        @(negedge clk);
        aresetn = 1'b1;
        pulses = 0;
        repeat (4) begin
            edge_a();
            if (sd_a) pulses++;
        end
        chk("post_rst_pulses", pulses, 0);
        chk("post_rst_sel", int'(os_a), 0);

        if (!b_done) begin
            repeat (50) begin
                if (!b_done) edge_a();
            end
        end
        chk("b_sequence_done", int'(b_done), 1);
        run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sel_mux_dwell.md
SEL_MUX_DWELL -- requirements
Module: sel_mux_dwell

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width per channel.
REQ-002 SHALL have parameter NCH, default 4, channel count (2..16).
REQ-003 SHALL have parameter DWELL, default 3, number of consecutive sampling edges a new request must hold before it is committed (1..255).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port aresetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_data  input  NCH*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port sel  input  $clog2(NCH)  requested channel.
REQ-008 SHALL have ports sel_en1 and sel_en2  input  1 each  qualifiers; sel is honoured only when both are 1.
REQ-009 SHALL have port out_data  output  WIDTH  registered selected data.
REQ-010 SHALL have port out_sel  output  $clog2(NCH)  currently committed channel.
REQ-011 SHALL have port pending  output  1  high while a switch request is being qualified.
REQ-012 SHALL have port switch_done  output  1  one-cycle pulse after a commit.

Function
REQ-013 Candidate SHALL be sel when sel_en1 & sel_en2 = 1 and sel < NCH; otherwise channel 0 (default channel).
REQ-014 FSM SHALL have two states: LOCK (candidate equals out_sel) and QUAL (candidate differs, counting).
REQ-015 In LOCK, a sampled candidate != out_sel SHALL load cnt=1; if DWELL=1 it commits on that edge, otherwise the FSM enters QUAL.
REQ-016 In QUAL, the same candidate SHALL increment cnt; at the edge where cnt would reach DWELL, out_sel SHALL load the candidate and the FSM SHALL return to LOCK.
REQ-017 In QUAL, a different candidate != out_sel SHALL restart qualification (cnt=1, new candidate captured), with no commit.
REQ-018 In QUAL, a candidate equal to out_sel SHALL abort to LOCK, cnt=0, no switch_done.
REQ-019 switch_done SHALL be high for exactly the cycle following each commit edge; back-to-back commits SHALL produce separate pulses.
REQ-020 pending SHALL equal (state == QUAL) as a registered output.
REQ-021 out_data SHALL update every edge to in_data channel out_sel (pre-edge value), giving one-cycle latency from in_data and from an out_sel change.
REQ-022 cnt SHALL be 8 bits wide and never wrap: it saturates at DWELL.

Reset
REQ-023 aresetn low SHALL immediately force out_data=0, out_sel=0, pending=0, switch_done=0, cnt=0, state=LOCK.
REQ-024 Reset asserted mid-qualification SHALL discard the pending candidate; no commit or pulse follows deassertion.
REQ-025 First active edge after deassertion SHALL evaluate the candidate as from LOCK on channel 0.

Structure
REQ-026 State enum (LOCK, QUAL) and the default-channel constant SHALL live in the shared package sel_mux_pkg.
REQ-027 Qualification counter SHALL be a sub-module dwell_counter (inputs: clear, load, inc; output: cnt, done).
REQ-028 Output data mux SHALL be the only combinational datapath; all outputs SHALL be flops.

Verification
REQ-029 Reset, WIDTH=8, NCH=4, DWELL=3, in_data=32'h44332211, sel=2, enables 1/1 held -> switch_done at edge 4, out_sel=2 after edge 3, out_data=8'h33 after edge 4.
REQ-030 sel=2 for 2 edges then sel=3 for 3 edges -> no pulse for 2; out_sel=3 after fifth edge; pending high edges 1..4.
REQ-031 sel=1, sel_en2 toggling 1,0,1 each edge -> candidate alternates 1/0; never commits; out_sel stays 0.
REQ-032 Locked on channel 2, drop sel_en1 for 3 edges -> out_sel returns to 0 with one switch_done pulse.
REQ-033 aresetn pulsed low during QUAL (cnt=2) -> all outputs 0 asynchronously; after release, no pulse and out_sel=0.
REQ-034 DWELL=1, NCH=3, sel=3 (out of range) then sel=1 -> sel=3 treated as 0 (no switch); sel=1 commits on the first edge.
